echo_mixer: RTL and testbench

Wet/dry mixer placed directly downstream of the echo stage. Once per audio frame it takes the dry input sample and the echo (wet) sample, scales each by an 8-bit gain, sums them and drives one mixed sample to the codec output path. It uses a bit-serial shift-add multiplier clocked by `bclk`, so it needs no DSP blocks. It fits comfortably inside the 64 `bclk` periods of one `lrclk` frame.

---
 rtl/echo_mixer.sv | 145 ++++++++++++++
 tb/tb_echo_mixer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/echo_mixer.sv
// Wet/dry mixer: per lrclk frame, dry*dry_gain + wet*wet_gain (Q1.7) via a bit-serial shift-add multiplier.
// Define ECHO_MIXER_SATURATION_EN to clamp to 16 bits and report clip; otherwise the result wraps.
module echo_mixer #(
    parameter int BITSIZE  = 16,
    parameter int GAINBITS = 8
) (
    input  logic                       bclk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       lrclk,
    input  logic signed [BITSIZE-1:0]  dry,
    input  logic signed [BITSIZE-1:0]  wet,
    input  logic        [GAINBITS-1:0] dry_gain,
    input  logic        [GAINBITS-1:0] wet_gain,
    output logic signed [BITSIZE-1:0]  out,
    output logic                       valid,
    output logic                       clip
);

    localparam int ACCW = BITSIZE + GAINBITS + 2;
    localparam int RESW = ACCW - 7;
    localparam int CNTW = $clog2(GAINBITS);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        MUL_DRY,
        MUL_WET,
        SUM,
        OUT
    } state_t;

    state_t                    state, next_state;
    logic                      lrclk_q;
    logic                      frame_start;
    logic signed [BITSIZE-1:0] dry_r, wet_r;
    logic [GAINBITS-1:0]       dry_gain_r, wet_gain_r;
    logic                      enable_r;
    logic signed [ACCW-1:0]    acc;
    logic [CNTW-1:0]           bit_cnt;
    logic                      last_bit;
    logic signed [BITSIZE-1:0] mul_sample;
    logic                      mul_bit;
    logic signed [ACCW-1:0]    addend;

    assign frame_start = lrclk & ~lrclk_q;
    assign last_bit    = (bit_cnt == CNTW'(GAINBITS - 1));

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (frame_start) next_state = LATCH;
            LATCH:   next_state = MUL_DRY;
            MUL_DRY: if (last_bit) next_state = MUL_WET;
            MUL_WET: if (last_bit) next_state = SUM;
            SUM:     next_state = OUT;
            OUT:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One partial product per cycle: sign-extended sample shifted by the current gain bit position.
    always_comb begin
        mul_sample = (state == MUL_WET) ? wet_r : dry_r;
        mul_bit    = (state == MUL_WET) ? wet_gain_r[bit_cnt] : dry_gain_r[bit_cnt];
        addend     = '0;
        if (mul_bit)
            addend = {{(ACCW - BITSIZE){mul_sample[BITSIZE-1]}}, mul_sample} <<< bit_cnt;
    end

`ifdef ECHO_MIXER_SATURATION_EN
    logic sat_hi, sat_lo;
    assign sat_hi = ~acc[RESW-1] & (|acc[RESW-2:BITSIZE-1]);
    assign sat_lo =  acc[RESW-1] & ~(&acc[RESW-2:BITSIZE-1]);
`else
    assign clip = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            lrclk_q    <= 1'b1;  // a high lrclk at reset release must not look like an edge
            dry_r      <= '0;
            wet_r      <= '0;
            dry_gain_r <= '0;
            wet_gain_r <= '0;
            enable_r   <= 1'b0;
            acc        <= '0;
            bit_cnt    <= '0;
            out        <= '0;
            valid      <= 1'b0;
`ifdef ECHO_MIXER_SATURATION_EN
            clip       <= 1'b0;
`endif
        end else begin
            state   <= next_state;
            lrclk_q <= lrclk;
            valid   <= 1'b0;
            case (state)
                LATCH: begin
                    dry_r      <= dry;
                    wet_r      <= wet;
                    dry_gain_r <= dry_gain;
                    wet_gain_r <= wet_gain;
                    enable_r   <= enable;
                    acc        <= '0;
                    bit_cnt    <= '0;
                end
                MUL_DRY, MUL_WET: begin
                    acc     <= acc + addend;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                SUM: acc <= acc >>> 7;
                OUT: begin
                    valid <= 1'b1;
                    if (!enable_r) begin
                        out <= dry_r;
`ifdef ECHO_MIXER_SATURATION_EN
                        clip <= 1'b0;
`endif
                    end else begin
`ifdef ECHO_MIXER_SATURATION_EN
                        if (sat_hi) begin
                            out  <= {1'b0, {(BITSIZE - 1){1'b1}}};
                            clip <= 1'b1;
                        end else if (sat_lo) begin
                            out  <= {1'b1, {(BITSIZE - 1){1'b0}}};
                            clip <= 1'b1;
                        end else begin
                            out  <= acc[BITSIZE-1:0];
                            clip <= 1'b0;
                        end
`else
                        out <= acc[BITSIZE-1:0];
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_echo_mixer.sv
// Self-checking bench for echo_mixer: expected samples are queued at each frame edge and
// compared (value, clip, latency) when valid pulses.
module tb_echo_mixer;

    logic               bclk = 1'b0;
    logic               reset;
    logic               enable;
    logic               lrclk;
    logic signed [15:0] dry, wet;
    logic [7:0]         dry_gain, wet_gain;
    logic signed [15:0] out;
    logic               valid;
    logic               clip;

    typedef struct {
        logic [15:0] out;
        logic        clip;
        int          edge_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_valid = 0;
    int          n_pushed = 0;
    logic        prev_valid = 1'b0;
    logic [15:0] last_out = '0;

    echo_mixer #(.BITSIZE(16), .GAINBITS(8)) dut (
        .bclk     (bclk),
        .reset    (reset),
        .enable   (enable),
        .lrclk    (lrclk),
        .dry      (dry),
        .wet      (wet),
        .dry_gain (dry_gain),
        .wet_gain (wet_gain),
        .out      (out),
        .valid    (valid),
        .clip     (clip)
    );

    always #5 bclk = ~bclk;
    always @(posedge bclk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [15:0] d, input logic signed [15:0] w,
                                   input logic [7:0] dg, input logic [7:0] wg, input logic en);
        exp_t   e;
        longint p, r;
        p = longint'(d) * longint'(dg) + longint'(w) * longint'(wg);
        r = p >>> 7;
        e.clip = 1'b0;
        e.edge_cyc = 0;
        if (!en) begin
            e.out = d;
        end else begin
`ifdef ECHO_MIXER_SATURATION_EN
            if (r > 32767) begin
                e.out = 16'h7fff;
                e.clip = 1'b1;
            end else if (r < -32768) begin
                e.out = 16'h8000;
                e.clip = 1'b1;
            end else begin
                e.out = r[15:0];
            end
`else
            e.out = r[15:0];
`endif
        end
        return e;
    endfunction

    // Scoreboard consumer: every valid pulse must match the oldest queued frame.
    always @(negedge bclk) begin
        if (valid) begin
            exp_t e;
            n_valid++;
            check("valid_one_cycle", {31'd0, prev_valid}, 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out", {16'd0, out}, {16'd0, e.out});
                check("clip", {31'd0, clip}, {31'd0, e.clip});
                check("latency", cyc - e.edge_cyc, 32'd19);
                last_out = e.out;
            end
        end
        prev_valid = valid;
    end

    // One 64-bclk frame; change_k/glitch_k < 0 disables the mid-frame dry change / lrclk glitch.
    task automatic run_frame(input logic signed [15:0] d, input logic signed [15:0] w,
                             input logic [7:0] dg, input logic [7:0] wg, input logic en,
                             input int change_k, input int glitch_k);
        exp_t e;
        @(negedge bclk);
        dry = d; wet = w; dry_gain = dg; wet_gain = wg; enable = en;
        lrclk = 1'b1;
        e = model(d, w, dg, wg, en);
        e.edge_cyc = cyc + 1;
        sb.push_back(e);
        n_pushed++;
        for (int k = 1; k < 64; k++) begin
            @(negedge bclk);
            if (k == 32) lrclk = 1'b0;
            if (k == change_k) dry = 16'sd9;
            if (k == glitch_k - 1) lrclk = 1'b0;
            if (k == glitch_k) lrclk = 1'b1;
            if (k == 40) check("out_hold", {16'd0, out}, {16'd0, last_out});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b1; lrclk = 1'b1;
        dry = '0; wet = '0; dry_gain = '0; wet_gain = '0;
        repeat (3) @(negedge bclk);
        check("rst_out", {16'd0, out}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_clip", {31'd0, clip}, 32'd0);

        // Release with lrclk already high: no frame may start.
        reset = 1'b0;
        repeat (30) @(negedge bclk);
        lrclk = 1'b0;
        repeat (32) @(negedge bclk);

        run_frame(16'sd1000, 16'sd0, 8'd128, 8'd0, 1'b1, -1, -1);
        run_frame(-16'sd1000, 16'sd300, 8'd64, 8'd128, 1'b1, -1, -1);
        run_frame(-16'sd1, 16'sd0, 8'd64, 8'd0, 1'b1, -1, -1);
        run_frame(16'sd20000, 16'sd20000, 8'd128, 8'd128, 1'b1, -1, -1);
        run_frame(-16'sd20000, -16'sd20000, 8'd128, 8'd128, 1'b1, -1, -1);
        run_frame(16'sd1234, 16'sd5000, 8'd255, 8'd255, 1'b0, -1, -1);
        run_frame(16'sd1234, 16'sd5000, 8'd255, 8'd255, 1'b1, 5, -1);
        run_frame(-16'sd32768, 16'sd32767, 8'd255, 8'd1, 1'b1, -1, -1);

        // Reset mid-frame: the aborted frame must never produce valid.
        @(negedge bclk);
        dry = 16'sd777; wet = 16'sd777; dry_gain = 8'd128; wet_gain = 8'd128; enable = 1'b1;
        lrclk = 1'b1;
        repeat (6) @(posedge bclk);
        #1 reset = 1'b1;
        #1;
        check("midrst_out", {16'd0, out}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        last_out = '0;
        @(negedge bclk);
        reset = 1'b0;
        repeat (10) @(negedge bclk);
        lrclk = 1'b0;
        repeat (40) @(negedge bclk);
        run_frame(16'sd1000, 16'sd0, 8'd128, 8'd0, 1'b1, -1, -1);

        // Back-to-back random frames, each with an lrclk glitch edge at cycle 10.
        for (int f = 0; f < 8; f++)
            run_frame(16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                      1'($urandom_range(0, 3) != 0), -1, 10);

        repeat (30) @(negedge bclk);
        check("sb_empty", sb.size(), 32'd0);
        check("valid_count", n_valid, n_pushed);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
